hwpe_tcdm_responder: RTL



---
 rtl/hwpe_tcdm_responder_pkg.sv | 26 ++
 rtl/hwpe_tcdm_responder_rr_arbiter.sv | 48 ++++
 rtl/hwpe_tcdm_responder.sv | 92 +++++++++
 3 files changed

// File: rtl/hwpe_tcdm_responder_pkg.sv
// Shared types and constants for the HWPE TCDM responder.
// The LFSR helper is used only when HWPE_TCDM_RESP_STALL_EN is defined.
package hwpe_tcdm_resp_package;

  localparam int unsigned TCDM_DATA_W = 32;
  localparam int unsigned TCDM_BE_W   = 4;
  localparam logic [15:0] STALL_SEED  = 16'hACE1;

  typedef struct packed {
    logic [31:0]            add;
    logic                   wen;
    logic [TCDM_BE_W-1:0]   be;
    logic [TCDM_DATA_W-1:0] data;
  } tcdm_req_t;

  typedef struct packed {
    logic [TCDM_DATA_W-1:0] r_data;
    logic                   r_valid;
  } tcdm_resp_t;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/hwpe_tcdm_responder_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner. Pointer holds when nothing is granted.
module hwpe_tcdm_rr_arbiter #(
  parameter int unsigned MP    = 4,
  localparam int unsigned IDX_W = (MP > 1) ? $clog2(MP) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [MP-1:0]    req_i,
  output logic [MP-1:0]    gnt_o,
  output logic [IDX_W-1:0] winner_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int unsigned      idx;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    gnt_o    = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned off = 0; off < MP; off++) begin
      idx = (int'(ptr_q) + off) % MP;
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        winner_o   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) ptr_d = (winner_o == IDX_W'(MP - 1)) ? '0 : winner_o + IDX_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/hwpe_tcdm_responder.sv
// Single-bank TCDM responder: round-robin arbitration, one-cycle response latency.
// Define HWPE_TCDM_RESP_STALL_EN to add LFSR-driven random grant withholding.
module hwpe_tcdm_responder
  import hwpe_tcdm_resp_package::*;
#(
  parameter int unsigned MP       = 4,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned ADDR_LSB = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [MP-1:0]                     tcdm_req_i,
  output logic [MP-1:0]                     tcdm_gnt_o,
  input  logic [MP-1:0][31:0]               tcdm_add_i,
  input  logic [MP-1:0]                     tcdm_wen_i,
  input  logic [MP-1:0][TCDM_BE_W-1:0]      tcdm_be_i,
  input  logic [MP-1:0][TCDM_DATA_W-1:0]    tcdm_data_i,
  output logic [MP-1:0][TCDM_DATA_W-1:0]    tcdm_r_data_o,
  output logic [MP-1:0]                     tcdm_r_valid_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned IDX_W = (MP > 1) ? $clog2(MP) : 1;

  tcdm_req_t        req_s [MP];
  tcdm_req_t        win_req;
  tcdm_resp_t       resp_q [MP];
  logic [IDX_W-1:0] winner;
  logic             any_gnt;
  logic             arb_en;
  logic [AW-1:0]    word_idx;
  logic [TCDM_DATA_W-1:0] mem_q [DEPTH];
  logic             unused_add;

  for (genvar i = 0; i < MP; i++) begin : g_port
    assign req_s[i] = '{add: tcdm_add_i[i], wen: tcdm_wen_i[i],
                        be: tcdm_be_i[i], data: tcdm_data_i[i]};
    assign tcdm_r_data_o[i]  = resp_q[i].r_data;
    assign tcdm_r_valid_o[i] = resp_q[i].r_valid;
  end

`ifdef HWPE_TCDM_RESP_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= STALL_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  assign arb_en = !rst_i && (lfsr_q[1:0] != 2'b00);
`else
  assign arb_en = !rst_i;
`endif

  hwpe_tcdm_rr_arbiter #(.MP(MP)) i_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (arb_en),
    .req_i    (tcdm_req_i),
    .gnt_o    (tcdm_gnt_o),
    .winner_o (winner)
  );

  assign any_gnt    = |tcdm_gnt_o;
  assign win_req    = req_s[winner];
  assign word_idx   = win_req.add[ADDR_LSB +: AW];
  // Upper address bits wrap silently; only the word-index slice is decoded.
  assign unused_add = ^tcdm_add_i;

  // NOTE: the memory array has no reset; its contents survive rst_i and a
  // reset-free array maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (any_gnt && !win_req.wen) begin
      for (int b = 0; b < TCDM_BE_W; b++) begin
        if (win_req.be[b]) mem_q[word_idx][8*b +: 8] <= win_req.data[8*b +: 8];
      end
    end
  end

  // Only one grant per cycle, so a read never collides with a same-cycle write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MP; i++) resp_q[i] <= '0;
    end else begin
      for (int i = 0; i < MP; i++) begin
        resp_q[i].r_valid <= tcdm_gnt_o[i];
        if (tcdm_gnt_o[i] && win_req.wen) resp_q[i].r_data <= mem_q[word_idx];
      end
    end
  end

endmodule
